// File: rtl/pwdlock_pkg.sv
// Shared types, timing defaults and the one-hot digit decoder for the keypad lock.
package pwdlock_pkg;

  // FAIL names the decision outcome; the verifier resolves it on the same edge
  // it is taken, so the state register never holds it.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    FAIL    = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  localparam int          DEF_CLK_HZ    = 400;
  localparam int          DEF_ENTRY_S   = 30;
  localparam int          DEF_OPEN_S    = 10;
  localparam int          DEF_LOCK_S    = 60;
  localparam int          DEF_MAX_TRIES = 3;
  localparam logic [23:0] DEF_PWD       = 24'h123456;

  // Returns {valid, bcd}; valid only when exactly one bit is set.
  function automatic logic [4:0] onehot_to_bcd(input logic [9:0] field);
    logic [3:0] digit;
    logic [3:0] ones;
    digit = 4'd0;
    ones  = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (field[k]) begin
        digit = 4'(k);
        ones  = ones + 4'd1;
      end
    end
    return {(ones == 4'd1), digit};
  endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: tick is high in the last cycle of each CLK_HZ-cycle period.
module sec_tick #(
  parameter int CLK_HZ = 400
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [W-1:0] count;

  assign tick = (count == W'(CLK_HZ - 1));

  // Clearing on a timer load makes the first tick land exactly CLK_HZ cycles later.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/password_verifier.sv
// Keypad lock controller: checks the six-digit entry buffer on confirm and
// drives open/lockout state, the seconds countdown and the buffer-clear strobe.
module password_verifier
  import pwdlock_pkg::*;
#(
  parameter int          CLK_HZ      = DEF_CLK_HZ,
  parameter int          ENTRY_S     = DEF_ENTRY_S,
  parameter int          OPEN_S      = DEF_OPEN_S,
  parameter int          LOCK_S      = DEF_LOCK_S,
  parameter int          MAX_TRIES   = DEF_MAX_TRIES,
  parameter logic [23:0] DEFAULT_PWD = DEF_PWD
) (
  input  logic       clk_400hz,
  input  logic       reset_n,
  input  logic       confirm,
  input  logic       set_mode,
  input  logic [9:0] pwds0,
  input  logic [9:0] pwds1,
  input  logic [9:0] pwds2,
  input  logic [9:0] pwds3,
  input  logic [9:0] pwds4,
  input  logic [9:0] pwds5,
  output logic [5:0] countdown,
  output logic       reset_stable,
  output logic       unlocked,
  output logic       alarm,
  output logic [1:0] tries_left
);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_ENTRY   = ENTRY;
  localparam logic [2:0] S_CHECK   = CHECK;
  localparam logic [2:0] S_OPEN    = OPEN;
  localparam logic [2:0] S_LOCKOUT = LOCKOUT;

  localparam logic [5:0] ENTRY_CD = 6'(ENTRY_S);
  localparam logic [5:0] OPEN_CD  = 6'(OPEN_S);
  localparam logic [5:0] LOCK_CD  = 6'(LOCK_S);
  localparam logic [1:0] TRIES_RST = 2'(MAX_TRIES);

  logic [2:0]  state, state_n;
  logic [23:0] stored_pwd, stored_pwd_n;
  logic [23:0] captured, captured_n;
  logic [5:0]  countdown_n;
  logic [1:0]  tries_n, fail_tries;
  logic        reset_stable_n;
  logic        conf_q, conf_edge;
  logic        load, tick;

  logic [9:0]  field [6];
  logic [4:0]  dec   [6];
  logic        all_valid, any_nonzero;
  logic [23:0] entry_bcd;

  assign conf_edge = confirm & ~conf_q;
  assign unlocked  = (state == S_OPEN);
  assign alarm     = (state == S_LOCKOUT);

  // Digit 0 occupies the top nibble so entry_bcd compares directly with the password.
  always_comb begin
    field[0] = pwds0;
    field[1] = pwds1;
    field[2] = pwds2;
    field[3] = pwds3;
    field[4] = pwds4;
    field[5] = pwds5;
    all_valid   = 1'b1;
    any_nonzero = 1'b0;
    entry_bcd   = '0;
    for (int i = 0; i < 6; i++) begin
      dec[i] = onehot_to_bcd(field[i]);
      all_valid   = all_valid & dec[i][4];
      any_nonzero = any_nonzero | (|field[i]);
      entry_bcd[23-4*i -: 4] = dec[i][3:0];
    end
  end

  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk     (clk_400hz),
    .reset_n (reset_n),
    .clear   (load),
    .tick    (tick)
  );

  always_comb begin
    state_n        = state;
    countdown_n    = countdown;
    tries_n        = tries_left;
    stored_pwd_n   = stored_pwd;
    captured_n     = captured;
    reset_stable_n = 1'b0;
    load           = 1'b0;
    fail_tries     = tries_left - 2'd1;
    case (state)
      S_IDLE: begin
        if (any_nonzero) begin
          state_n     = S_ENTRY;
          countdown_n = ENTRY_CD;
          load        = 1'b1;
        end
      end
      S_ENTRY: begin
        // A valid confirm beats an expiry in the same cycle.
        if (conf_edge && all_valid) begin
          state_n    = S_CHECK;
          captured_n = entry_bcd;
        end else if (countdown == 6'd0) begin
          tries_n        = fail_tries;
          reset_stable_n = 1'b1;
          if (fail_tries == 2'd0) begin
            state_n     = S_LOCKOUT;
            countdown_n = LOCK_CD;
            load        = 1'b1;
          end else begin
            state_n     = S_IDLE;
            countdown_n = 6'd0;
          end
        end else if (tick) begin
          countdown_n = countdown - 6'd1;
        end
      end
      S_CHECK: begin
        reset_stable_n = 1'b1;
        if (captured == stored_pwd) begin
          state_n     = S_OPEN;
          tries_n     = TRIES_RST;
          countdown_n = OPEN_CD;
          load        = 1'b1;
        end else begin
          tries_n = fail_tries;
          if (fail_tries == 2'd0) begin
            state_n     = S_LOCKOUT;
            countdown_n = LOCK_CD;
            load        = 1'b1;
          end else begin
            state_n     = S_IDLE;
            countdown_n = 6'd0;
          end
        end
      end
      S_OPEN: begin
        if (conf_edge && !set_mode) begin
          state_n        = S_IDLE;
          countdown_n    = 6'd0;
          reset_stable_n = 1'b1;
        end else if (conf_edge && all_valid) begin
          stored_pwd_n   = entry_bcd;
          countdown_n    = OPEN_CD;
          load           = 1'b1;
          reset_stable_n = 1'b1;
        end else if (countdown == 6'd0) begin
          state_n        = S_IDLE;
          reset_stable_n = 1'b1;
        end else if (tick) begin
          countdown_n = countdown - 6'd1;
        end
      end
      S_LOCKOUT: begin
        if (countdown == 6'd0) begin
          state_n        = S_IDLE;
          tries_n        = TRIES_RST;
          reset_stable_n = 1'b1;
        end else if (tick) begin
          countdown_n = countdown - 6'd1;
        end
      end
      default: begin
        state_n     = S_IDLE;
        countdown_n = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk_400hz) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      stored_pwd   <= DEFAULT_PWD;
      captured     <= '0;
      countdown    <= 6'd0;
      tries_left   <= TRIES_RST;
      reset_stable <= 1'b0;
      conf_q       <= 1'b0;
    end else begin
      state        <= state_n;
      stored_pwd   <= stored_pwd_n;
      captured     <= captured_n;
      countdown    <= countdown_n;
      tries_left   <= tries_n;
      reset_stable <= reset_stable_n;
      conf_q       <= confirm;
    end
  end

endmodule
